// File: rtl/spi_flash_target.sv
// Device side of a 25-series SPI NOR flash (mode 0, MSB first): READ, JEDEC-ID, STATUS,
// power-down and wake, with oversampled SPI pins and a synchronous external memory read port.
module spi_flash_target #(
  parameter int          MEM_AW   = 16,
  parameter logic [23:0] JEDEC_ID = 24'hC84015,
  parameter logic [7:0]  STATUS   = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cs,
  input  logic              i_sclk,
  input  logic              i_copi,
  output logic              o_cipo,
  output logic              o_cipo_oe,
  output logic              o_mem_rd,
  output logic [MEM_AW-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_READ, ST_ID, ST_STAT, ST_IGNORE
  } state_e;

  typedef enum logic [1:0] {
    PEND_NONE, PEND_SLEEP, PEND_WAKE
  } pend_e;

  logic [1:0] cs_sync_q, sclk_sync_q, copi_sync_q;
  logic       sclk_prev_q, cs_prev_q, armed_q;
  logic [1:0] settle_q;
  logic       cs_s, sclk_s, copi_s;
  logic       rise_s, fall_s, cs_rise_s, cs_fall_s;

  state_e            state_q, state_d;
  pend_e             pend_q, pend_d;
  logic              awake_q, awake_d;
  logic [22:0]       shreg_q, shreg_d;
  logic [4:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        tx_q, tx_d;
  logic              cipo_q, cipo_d;
  logic              oe_q, oe_d;
  logic              mem_rd_q, mem_rd_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              rd_vld_q, rd_vld_d;
  logic              pf_req_q, pf_req_d;
  logic [7:0]        pf_buf_q, pf_buf_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic              rise_seen_q, rise_seen_d;
  logic [1:0]        id_idx_q, id_idx_d;
  logic [23:0]       rx_next_s;
  logic [7:0]        next_byte_s;
  logic              unused_rx_s;

  // Pin synchronisers and edge history; CS-fall detection is armed only once CS has really been seen high
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cs_sync_q   <= 2'b11;
      sclk_sync_q <= 2'b00;
      copi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], i_cs};
      sclk_sync_q <= {sclk_sync_q[0], i_sclk};
      copi_sync_q <= {copi_sync_q[0], i_copi};
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
      settle_q    <= (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
      armed_q     <= armed_q | ((settle_q == 2'd2) & cs_sync_q[1]);
    end
  end

  assign cs_s        = cs_sync_q[1];
  assign sclk_s      = sclk_sync_q[1];
  assign copi_s      = copi_sync_q[1];
  assign rise_s      = sclk_s & ~sclk_prev_q & ~cs_s;
  assign fall_s      = ~sclk_s & sclk_prev_q & ~cs_s;
  assign cs_rise_s   = cs_s & ~cs_prev_q;
  assign cs_fall_s   = ~cs_s & cs_prev_q;
  assign unused_rx_s = ^rx_next_s;

  // Transaction FSM and datapath next-state
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    awake_d     = awake_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    tx_d        = tx_q;
    cipo_d      = cipo_q;
    oe_d        = oe_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    addr_d      = addr_q;
    rd_vld_d    = mem_rd_q;
    pf_req_d    = 1'b0;
    pf_buf_d    = pf_buf_q;
    fcnt_d      = fcnt_q;
    rise_seen_d = rise_seen_q;
    id_idx_d    = id_idx_q;
    rx_next_s   = {shreg_q, copi_s};
    next_byte_s = 8'h00;

    case (state_q)
      ST_READ: next_byte_s = pf_buf_q;
      ST_STAT: next_byte_s = STATUS;
      ST_ID: begin
        case (id_idx_q)
          2'd1:    next_byte_s = JEDEC_ID[15:8];
          2'd2:    next_byte_s = JEDEC_ID[7:0];
          default: next_byte_s = 8'h00;
        endcase
      end
      default: next_byte_s = 8'h00;
    endcase

    if (cs_rise_s) begin
      state_d     = ST_IDLE;
      oe_d        = 1'b0;
      cipo_d      = 1'b0;
      bitcnt_d    = 5'd0;
      fcnt_d      = 3'd0;
      rise_seen_d = 1'b0;
      pend_d      = PEND_NONE;
      // Sleep/wake only commit when CS rises on a whole-byte boundary
      if ((bitcnt_q[2:0] == 3'd0) && (pend_q == PEND_SLEEP)) begin
        awake_d = 1'b0;
      end else if ((bitcnt_q[2:0] == 3'd0) && (pend_q == PEND_WAKE)) begin
        awake_d = 1'b1;
      end else begin
        awake_d = awake_q;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall_s && armed_q) begin
            state_d  = ST_CMD;
            bitcnt_d = 5'd0;
            shreg_d  = 23'h0;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_CMD: begin
          if (rise_s) begin
            shreg_d = rx_next_s[22:0];
            if (bitcnt_q == 5'd7) begin
              bitcnt_d = 5'd0;
              if (!awake_q) begin
                state_d = ST_IGNORE;
                pend_d  = (rx_next_s[7:0] == 8'hAB) ? PEND_WAKE : PEND_NONE;
              end else begin
                case (rx_next_s[7:0])
                  8'h03: state_d = ST_ADDR;
                  8'h9F: begin
                    state_d     = ST_ID;
                    id_idx_d    = 2'd1;
                    tx_d        = JEDEC_ID[23:16];
                    cipo_d      = JEDEC_ID[23];
                    oe_d        = 1'b1;
                    fcnt_d      = 3'd0;
                    rise_seen_d = 1'b0;
                  end
                  8'h05: begin
                    state_d     = ST_STAT;
                    tx_d        = STATUS;
                    cipo_d      = STATUS[7];
                    oe_d        = 1'b1;
                    fcnt_d      = 3'd0;
                    rise_seen_d = 1'b0;
                  end
                  8'hB9: begin
                    state_d = ST_IGNORE;
                    pend_d  = PEND_SLEEP;
                  end
                  8'hAB: begin
                    state_d = ST_IGNORE;
                    pend_d  = PEND_WAKE;
                  end
                  default: state_d = ST_IGNORE;
                endcase
              end
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end else begin
            shreg_d = shreg_q;
          end
        end

        ST_ADDR: begin
          if (rd_vld_q) begin
            state_d     = ST_READ;
            tx_d        = i_mem_data;
            cipo_d      = i_mem_data[7];
            oe_d        = 1'b1;
            fcnt_d      = 3'd0;
            rise_seen_d = 1'b0;
          end else if (rise_s) begin
            shreg_d = rx_next_s[22:0];
            if (bitcnt_q == 5'd23) begin
              bitcnt_d   = 5'd0;
              mem_rd_d   = 1'b1;
              mem_addr_d = rx_next_s[MEM_AW-1:0];
              addr_d     = rx_next_s[MEM_AW-1:0];
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end else begin
            bitcnt_d = bitcnt_q;
          end
        end

        ST_READ, ST_ID, ST_STAT: begin
          // The falling edge trailing the command/address byte is skipped via rise_seen
          if (rise_s) begin
            rise_seen_d = 1'b1;
          end else if (fall_s && rise_seen_q) begin
            rise_seen_d = 1'b0;
            fcnt_d      = fcnt_q + 3'd1;
            if (fcnt_q == 3'd7) begin
              tx_d     = next_byte_s;
              cipo_d   = next_byte_s[7];
              id_idx_d = ((state_q == ST_ID) && (id_idx_q != 2'd3)) ? id_idx_q + 2'd1 : id_idx_q;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              cipo_d   = tx_q[6];
              pf_req_d = (state_q == ST_READ) && (fcnt_q == 3'd0);
            end
          end else begin
            rise_seen_d = rise_seen_q;
          end
          if (pf_req_q) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
            addr_d     = addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
          end else begin
            mem_rd_d = 1'b0;
          end
          if (rd_vld_q) begin
            pf_buf_d = i_mem_data;
          end else begin
            pf_buf_d = pf_buf_q;
          end
        end

        ST_IGNORE: begin
          oe_d = 1'b0;
          if (rise_s) begin
            bitcnt_d = bitcnt_q + 5'd1;
          end else begin
            bitcnt_d = bitcnt_q;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= PEND_NONE;
      awake_q     <= 1'b1;
      shreg_q     <= 23'h0;
      bitcnt_q    <= 5'd0;
      tx_q        <= 8'h00;
      cipo_q      <= 1'b0;
      oe_q        <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= {MEM_AW{1'b0}};
      addr_q      <= {MEM_AW{1'b0}};
      rd_vld_q    <= 1'b0;
      pf_req_q    <= 1'b0;
      pf_buf_q    <= 8'h00;
      fcnt_q      <= 3'd0;
      rise_seen_q <= 1'b0;
      id_idx_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      awake_q     <= awake_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      tx_q        <= tx_d;
      cipo_q      <= cipo_d;
      oe_q        <= oe_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      addr_q      <= addr_d;
      rd_vld_q    <= rd_vld_d;
      pf_req_q    <= pf_req_d;
      pf_buf_q    <= pf_buf_d;
      fcnt_q      <= fcnt_d;
      rise_seen_q <= rise_seen_d;
      id_idx_q    <= id_idx_d;
    end
  end

  assign o_cipo     = cipo_q;
  assign o_cipo_oe  = oe_q;
  assign o_mem_rd   = mem_rd_q;
  assign o_mem_addr = mem_addr_q;

endmodule

// File: tb/tb_spi_flash_target.sv
// Bench for spi_flash_target: drives an SPI controller (SCLK = clk/8) against a memory model
// and checks responses against a flat-array reference of the flash contents.
module tb_spi_flash_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        sclk;
  logic        copi;
  logic        cipo;
  logic        cipo_oe;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q [$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  spi_flash_target dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cs       (cs),
    .i_sclk     (sclk),
    .i_copi     (copi),
    .o_cipo     (cipo),
    .o_cipo_oe  (cipo_oe),
    .o_mem_rd   (mem_rd),
    .o_mem_addr (mem_addr),
    .i_mem_data (mem_data)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data one clock after the strobe; every strobe address is logged
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_data <= mem[mem_addr];
      rd_q.push_back(mem_addr);
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got no end of run, want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] ref_byte(input logic [23:0] a, input int k);
    logic [15:0] idx;
    idx = a[15:0] + 16'(k);
    return mem[idx];
  endfunction

  task automatic cs_begin();
    @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Shift nbits of b (MSB first); CIPO/OE are sampled just before each rising SCLK edge
  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r,
                          output logic oe_any, output logic oe_all);
    r = 8'h00;
    oe_any = 1'b0;
    oe_all = 1'b1;
    for (int i = 7; i > 7 - nbits; i--) begin
      copi = b[i];
      repeat (4) @(negedge clk);
      r[i]   = cipo;
      oe_any = oe_any | cipo_oe;
      oe_all = oe_all & cipo_oe;
      sclk   = 1'b1;
      repeat (4) @(negedge clk);
      sclk   = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (cipo !== 1'b0) begin n_fail++; $display("FAIL reset_cipo: got %b want 0", cipo); end
    n_cmp++; if (cipo_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", cipo_oe); end
    n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
  endtask

  task automatic test_jedec(input string tag);
    logic [7:0]  r;
    logic        any, all;
    logic [7:0]  exp_b [4];
    exp_b = '{8'hC8, 8'h40, 8'h15, 8'h00};
    cs_begin();
    spi_bits(8'h9F, 8, r, any, all);
    n_cmp++; if (any !== 1'b0) begin n_fail++; $display("FAIL %s_cmd_oe: got %b want 0", tag, any); end
    for (int k = 0; k < 4; k++) begin
      spi_bits(8'h00, 8, r, any, all);
      n_cmp++; if (r !== exp_b[k]) begin n_fail++; $display("FAIL %s_byte%0d: got %h want %h", tag, k, r, exp_b[k]); end
      n_cmp++; if (all !== 1'b1) begin n_fail++; $display("FAIL %s_oe%0d: got %b want 1", tag, k, all); end
    end
    cs_end();
    n_cmp++; if (cipo_oe !== 1'b0) begin n_fail++; $display("FAIL %s_oe_after_cs: got %b want 0", tag, cipo_oe); end
  endtask

  task automatic test_read_at(input logic [23:0] a, input int n, input string tag);
    logic [7:0] r, exp_r;
    logic       any, all, cmd_oe;
    rd_q.delete();
    cs_begin();
    spi_bits(8'h03, 8, r, any, all);
    cmd_oe = any;
    spi_bits(a[23:16], 8, r, any, all); cmd_oe = cmd_oe | any;
    spi_bits(a[15:8], 8, r, any, all);  cmd_oe = cmd_oe | any;
    spi_bits(a[7:0], 8, r, any, all);   cmd_oe = cmd_oe | any;
    n_cmp++; if (cmd_oe !== 1'b0) begin n_fail++; $display("FAIL %s_cmd_oe: got %b want 0", tag, cmd_oe); end
    for (int k = 0; k < n; k++) begin
      exp_r = ref_byte(a, k);
      spi_bits(8'h00, 8, r, any, all);
      n_cmp++; if (r !== exp_r) begin n_fail++; $display("FAIL %s_byte%0d: got %h want %h", tag, k, r, exp_r); end
      n_cmp++; if (all !== 1'b1) begin n_fail++; $display("FAIL %s_oe%0d: got %b want 1", tag, k, all); end
    end
    cs_end();
    // One initial fetch plus one prefetch issued during each byte shifted out
    n_cmp++; if (rd_q.size() !== n + 1) begin n_fail++; $display("FAIL %s_rd_count: got %0d want %0d", tag, rd_q.size(), n + 1); end
    for (int j = 0; j < rd_q.size() && j <= n; j++) begin
      n_cmp++;
      if (rd_q[j] !== a[15:0] + 16'(j)) begin
        n_fail++; $display("FAIL %s_rd_addr%0d: got %h want %h", tag, j, rd_q[j], a[15:0] + 16'(j));
      end
    end
    n_cmp++; if (cipo_oe !== 1'b0) begin n_fail++; $display("FAIL %s_oe_after_cs: got %b want 0", tag, cipo_oe); end
  endtask

  task automatic test_read_basic();
    mem[16'h0010] = 8'hA5;
    mem[16'h0011] = 8'h5A;
    mem[16'h0012] = 8'h3C;
    test_read_at(24'h000010, 3, "read_basic");
  endtask

  task automatic test_read_wrap();
    mem[16'hFFFF] = 8'h11;
    mem[16'h0000] = 8'h22;
    test_read_at(24'h00FFFF, 2, "read_wrap");
  endtask

  task automatic test_read_random();
    for (int it = 0; it < 4; it++) begin
      test_read_at(24'($urandom), $urandom_range(1, 4), "read_rand");
    end
  endtask

  task automatic test_status();
    logic [7:0] r;
    logic       any, all;
    int         n;
    n = $urandom_range(1, 3);
    cs_begin();
    spi_bits(8'h05, 8, r, any, all);
    for (int k = 0; k < n; k++) begin
      spi_bits(8'($urandom), 8, r, any, all);
      n_cmp++; if (r !== 8'h00) begin n_fail++; $display("FAIL status_byte%0d: got %h want 00", k, r); end
      n_cmp++; if (all !== 1'b1) begin n_fail++; $display("FAIL status_oe%0d: got %b want 1", k, all); end
    end
    cs_end();
  endtask

  task automatic test_unknown_cmd();
    logic [7:0] r, cmd;
    logic       any, all;
    cmd = 8'($urandom);
    while (cmd == 8'h03 || cmd == 8'h9F || cmd == 8'h05 || cmd == 8'hB9 || cmd == 8'hAB) cmd = 8'($urandom);
    rd_q.delete();
    cs_begin();
    spi_bits(cmd, 8, r, any, all);
    spi_bits(8'($urandom), 8, r, any, all);
    spi_bits(8'($urandom), 8, r, any, all);
    cs_end();
    n_cmp++; if (any !== 1'b0) begin n_fail++; $display("FAIL unknown_cmd_oe: cmd %h got %b want 0", cmd, any); end
    n_cmp++; if (rd_q.size() !== 0) begin n_fail++; $display("FAIL unknown_cmd_rd: got %0d want 0", rd_q.size()); end
  endtask

  task automatic test_power();
    logic [7:0] r;
    logic       any, all;
    // Power-down followed by stray bits off a byte boundary must not take effect
    cs_begin();
    spi_bits(8'hB9, 8, r, any, all);
    spi_bits(8'hFF, 3, r, any, all);
    cs_end();
    test_jedec("pd_partial_jedec");
    cs_begin(); spi_bits(8'hB9, 8, r, any, all); cs_end();
    rd_q.delete();
    cs_begin();
    spi_bits(8'h9F, 8, r, any, all);
    spi_bits(8'h00, 8, r, any, all);
    spi_bits(8'h00, 8, r, any, all);
    cs_end();
    n_cmp++; if (any !== 1'b0) begin n_fail++; $display("FAIL asleep_jedec_oe: got %b want 0", any); end
    cs_begin();
    spi_bits(8'h03, 8, r, any, all);
    for (int k = 0; k < 4; k++) spi_bits(8'h00, 8, r, any, all);
    cs_end();
    n_cmp++; if (any !== 1'b0) begin n_fail++; $display("FAIL asleep_read_oe: got %b want 0", any); end
    n_cmp++; if (rd_q.size() !== 0) begin n_fail++; $display("FAIL asleep_read_rd: got %0d want 0", rd_q.size()); end
    cs_begin(); spi_bits(8'hAB, 8, r, any, all); cs_end();
    test_jedec("wake_jedec");
  endtask

  task automatic test_abort_addr();
    logic [7:0] r;
    logic       any, all;
    rd_q.delete();
    cs_begin();
    spi_bits(8'h03, 8, r, any, all);
    spi_bits(8'h00, 8, r, any, all);
    spi_bits(8'h12, 4, r, any, all);
    cs_end();
    cs_begin();
    spi_bits(8'h05, 8, r, any, all);
    for (int k = 0; k < 2; k++) begin
      spi_bits(8'h00, 8, r, any, all);
      n_cmp++; if (r !== 8'h00) begin n_fail++; $display("FAIL abort_status%0d: got %h want 00", k, r); end
      n_cmp++; if (all !== 1'b1) begin n_fail++; $display("FAIL abort_status_oe%0d: got %b want 1", k, all); end
    end
    cs_end();
    n_cmp++; if (rd_q.size() !== 0) begin n_fail++; $display("FAIL abort_rd_count: got %0d want 0", rd_q.size()); end
  endtask

  task automatic test_rst_mid_read();
    logic [7:0] r;
    logic       any, all;
    cs_begin();
    spi_bits(8'h03, 8, r, any, all);
    spi_bits(8'h00, 8, r, any, all);
    spi_bits(8'h00, 8, r, any, all);
    spi_bits(8'h20, 8, r, any, all);
    spi_bits(8'h00, 3, r, any, all);
    n_cmp++; if (cipo_oe !== 1'b1) begin n_fail++; $display("FAIL rst_pre_oe: got %b want 1", cipo_oe); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (cipo_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe: got %b want 0", cipo_oe); end
    n_cmp++; if (cipo !== 1'b0) begin n_fail++; $display("FAIL rst_cipo: got %b want 0", cipo); end
    n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rst_mem_rd: got %b want 0", mem_rd); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cs  = 1'b1;
    repeat (8) @(negedge clk);
    test_jedec("rst_jedec");
  endtask

  initial begin
    rst  = 1'b1;
    cs   = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (6) @(negedge clk);
    test_jedec("jedec");
    test_read_basic();
    test_read_wrap();
    test_read_random();
    test_status();
    test_unknown_cmd();
    test_power();
    test_abort_addr();
    test_rst_mid_read();
    test_status();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
